ex_stage: RTL

Execute stage of the pipelined MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes that register's control, sign-extended immediate, register data and rs/rt/rd outputs. It applies EX/MEM and MEM/WB forwarding and runs the ALU. It contains an iterative multiply/divide unit with HI/LO registers and drives the registered EX/MEM fields. While mult/div is busy it asserts a stall to the hazard unit.

---
 rtl/ex_stage_pkg.sv | 50 +++++
 rtl/ex_stage_mdu.sv | 150 +++++++++++++++
 rtl/ex_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALUOp values, funct codes,
// ID/EX control bit positions and the multiply/divide FSM states.
package ex_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam int CTL_REGDST   = 0;
    localparam int CTL_REGWRITE = 1;
    localparam int CTL_ALUSRC   = 2;
    localparam int CTL_ALUOP_HI = 3;
    localparam int CTL_ALUOP_LO = 4;
    localparam int CTL_MEMWRITE = 5;
    localparam int CTL_MEMREAD  = 6;
    localparam int CTL_MEMTOREG = 7;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Iterative multiply/divide unit: one product/quotient bit per cycle,
// sign handled by magnitude conversion at issue and correction at the end.
module mdu_iter
    import ex_stage_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              stall,
    output logic              bubble,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg_wide(input logic neg, input logic [2*DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

    mdu_state_t state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   hi_r, lo_r, hi_nxt, lo_nxt;

    logic [2*DATA_W-1:0] mcand_p0, prod_p0;
    logic [DATA_W-1:0]   mplier_p0, quo_p0, rem_p0, divisor_p0;
    logic                neg_q_p0, neg_r_p0, div0_p0;

    logic                signed_op, sgn_a, sgn_b, is_mul;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] prod_nxt, prod_fin;
    logic [DATA_W:0]     rem_sh, rem_sub;
    logic                ge;
    logic [DATA_W-1:0]   rem_nxt, quo_nxt;

    assign signed_op = (funct == FN_MULT) || (funct == FN_DIV);
    assign is_mul    = (funct == FN_MULT) || (funct == FN_MULTU);
    assign sgn_a     = signed_op & a[DATA_W-1];
    assign sgn_b     = signed_op & b[DATA_W-1];
    assign mag_a     = cond_neg(sgn_a, a);
    assign mag_b     = cond_neg(sgn_b, b);

    assign prod_nxt  = mplier_p0[0] ? (prod_p0 + mcand_p0) : prod_p0;
    assign prod_fin  = cond_neg_wide(neg_q_p0, prod_nxt);

    // Restoring step: the borrow out of the 33-bit subtract decides the quotient bit.
    assign rem_sh    = {rem_p0, quo_p0[DATA_W-1]};
    assign rem_sub   = rem_sh - {1'b0, divisor_p0};
    assign ge        = ~rem_sub[DATA_W];
    assign rem_nxt   = ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quo_nxt   = {quo_p0[DATA_W-2:0], ge};

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        hi_nxt    = hi_r;
        lo_nxt    = lo_r;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    state_nxt = is_mul ? MDU_MUL : MDU_DIV;
                    count_nxt = '0;
                end
            end
            MDU_MUL: begin
                if (count == CNT_LAST) begin
                    state_nxt = MDU_DONE;
                    hi_nxt    = prod_fin[2*DATA_W-1:DATA_W];
                    lo_nxt    = prod_fin[DATA_W-1:0];
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            MDU_DIV: begin
                if (div0_p0) begin
                    state_nxt = MDU_DONE;
                    lo_nxt    = DIV0_QUOT;
                    hi_nxt    = cond_neg(neg_r_p0, quo_p0);
                end else if (count == CNT_LAST) begin
                    state_nxt = MDU_DONE;
                    lo_nxt    = cond_neg(neg_q_p0, quo_nxt);
                    hi_nxt    = cond_neg(neg_r_p0, rem_nxt);
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MDU_IDLE;
            count <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            hi_r  <= hi_nxt;
            lo_r  <= lo_nxt;
        end
    end

    // Working registers: loaded at issue, only meaningful while busy.
    always_ff @(posedge clk) begin
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    mcand_p0   <= {{DATA_W{1'b0}}, mag_a};
                    mplier_p0  <= mag_b;
                    prod_p0    <= '0;
                    quo_p0     <= mag_a;
                    rem_p0     <= '0;
                    divisor_p0 <= mag_b;
                    neg_q_p0   <= sgn_a ^ sgn_b;
                    neg_r_p0   <= sgn_a;
                    div0_p0    <= (mag_b == '0);
                end
            end
            MDU_MUL: begin
                prod_p0   <= prod_nxt;
                mcand_p0  <= mcand_p0 << 1;
                mplier_p0 <= mplier_p0 >> 1;
            end
            MDU_DIV: begin
                rem_p0 <= rem_nxt;
                quo_p0 <= quo_nxt;
            end
            default: ;
        endcase
    end

    assign stall  = ((state == MDU_IDLE) && start) || (state == MDU_MUL) || (state == MDU_DIV);
    assign bubble = stall || (state == MDU_DONE);
    assign hi     = hi_r;
    assign lo     = lo_r;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, HI/LO via the iterative
// multiply/divide unit, and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:7]        control,
    input  logic [DATA_W-1:0] signExtOut,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              exmem_regwrite_fb,
    input  logic [4:0]        exmem_rd_fb,
    input  logic [DATA_W-1:0] exmem_alu_fb,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [0:3]        exmem_control,
    output logic [DATA_W-1:0] exmem_alu,
    output logic [DATA_W-1:0] exmem_wdata,
    output logic [4:0]        exmem_rd
);

    logic [1:0]               alu_op;
    logic [5:0]               funct;
    logic [4:0]               shamt;
    logic                     mdu_start, mdu_bubble;
    logic [DATA_W-1:0]        hi, lo;
    logic [DATA_W-1:0]        fwd_a_p0, fwd_b_p0, alu_res_p0;
    logic signed [DATA_W-1:0] alu_a_p0, alu_b_p0;

    assign alu_op    = control[CTL_ALUOP_HI:CTL_ALUOP_LO];
    assign funct     = signExtOut[5:0];
    assign shamt     = signExtOut[10:6];
    assign mdu_start = (alu_op == ALUOP_FUNCT) && is_mdu_funct(funct);

    // EX/MEM result outranks WB: it is the younger write to the same register.
    always_comb begin
        fwd_a_p0 = rdata1;
        if (exmem_regwrite_fb && (exmem_rd_fb != 5'd0) && (exmem_rd_fb == rs))
            fwd_a_p0 = exmem_alu_fb;
        else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
            fwd_a_p0 = wb_data;

        fwd_b_p0 = rdata2;
        if (exmem_regwrite_fb && (exmem_rd_fb != 5'd0) && (exmem_rd_fb == rt))
            fwd_b_p0 = exmem_alu_fb;
        else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rt))
            fwd_b_p0 = wb_data;
    end

    assign alu_a_p0 = fwd_a_p0;
    assign alu_b_p0 = control[CTL_ALUSRC] ? signExtOut : fwd_b_p0;

    always_comb begin
        alu_res_p0 = '0;
        case (alu_op)
            ALUOP_ADD: alu_res_p0 = alu_a_p0 + alu_b_p0;
            ALUOP_SUB: alu_res_p0 = alu_a_p0 - alu_b_p0;
            ALUOP_OR:  alu_res_p0 = alu_a_p0 | alu_b_p0;
            default: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_res_p0 = alu_a_p0 + alu_b_p0;
                    FN_SUB, FN_SUBU: alu_res_p0 = alu_a_p0 - alu_b_p0;
                    FN_AND:  alu_res_p0 = alu_a_p0 & alu_b_p0;
                    FN_OR:   alu_res_p0 = alu_a_p0 | alu_b_p0;
                    FN_XOR:  alu_res_p0 = alu_a_p0 ^ alu_b_p0;
                    FN_NOR:  alu_res_p0 = ~(alu_a_p0 | alu_b_p0);
                    FN_SLT:  alu_res_p0 = {{(DATA_W-1){1'b0}}, (alu_a_p0 < alu_b_p0)};
                    FN_SLTU: alu_res_p0 = {{(DATA_W-1){1'b0}}, ($unsigned(alu_a_p0) < $unsigned(alu_b_p0))};
                    FN_SLL:  alu_res_p0 = $unsigned(alu_b_p0) << shamt;
                    FN_SRL:  alu_res_p0 = $unsigned(alu_b_p0) >> shamt;
                    FN_SRA:  alu_res_p0 = alu_b_p0 >>> shamt;
                    FN_MFHI: alu_res_p0 = hi;
                    FN_MFLO: alu_res_p0 = lo;
                    default: alu_res_p0 = '0;
                endcase
            end
        endcase
    end

    mdu_iter #(
        .DATA_W    (DATA_W),
        .DIV0_QUOT (DIV0_QUOT)
    ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .funct  (funct),
        .a      (fwd_a_p0),
        .b      (fwd_b_p0),
        .stall  (stall),
        .bubble (mdu_bubble),
        .hi     (hi),
        .lo     (lo)
    );

    // EX -> EX/MEM boundary; MDU issue, busy and done cycles leave a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_control <= '0;
            exmem_alu     <= '0;
            exmem_wdata   <= '0;
            exmem_rd      <= '0;
        end else if (mdu_bubble) begin
            exmem_control <= '0;
        end else begin
            exmem_control <= {control[CTL_REGWRITE], control[CTL_MEMWRITE],
                              control[CTL_MEMREAD], control[CTL_MEMTOREG]};
            exmem_alu     <= alu_res_p0;
            exmem_wdata   <= fwd_b_p0;
            exmem_rd      <= control[CTL_REGDST] ? rd : rt;
        end
    end

endmodule
